// File: rtl/cnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_layer_sequencer
//  Description : Top-level inference scheduler for the QuickDraw CNN datapath.
//                Drives the layer engines (conv1, pool1, conv2, pool2, fc1,
//                fc2) strictly in order, one start/done handshake per layer,
//                with per-layer timeout detection, abort and cycle counters.
//
//  Ports
//    clk          : clock
//    reset        : asynchronous, active-high reset
//    run          : single-cycle pulse starting a full inference
//    abort        : synchronous abort, highest priority after reset
//    layer_done   : level done flags from the engines
//    layer_start  : one-hot (or zero) registered start levels to the engines
//    busy         : high in ARM, RUN and RELEASE
//    all_done     : sticky success flag
//    error        : sticky timeout flag
//    err_layer    : index of the layer that timed out
//    cur_layer    : index of the layer currently being driven
//    layer_cycles : start-to-done cycle count of the last completed layer
//    total_cycles : cycles from run accepted to FINISH entry (saturating)
//
//  Revision    : 1.0  initial release
// ============================================================================
module cnn_layer_sequencer #(
    parameter int NUM_LAYERS     = 6,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 32,
    localparam int c_IDX_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [NUM_LAYERS-1:0] layer_start,
    output logic                  busy,
    output logic                  all_done,
    output logic                  error,
    output logic [c_IDX_W-1:0]    err_layer,
    output logic [c_IDX_W-1:0]    cur_layer,
    output logic [CNT_W-1:0]      layer_cycles,
    output logic [CNT_W-1:0]      total_cycles
);

    localparam logic [c_IDX_W-1:0]    c_LAST_LAYER = c_IDX_W'(NUM_LAYERS - 1);
    localparam logic [c_IDX_W-1:0]    c_IDX_ONE    = c_IDX_W'(1);
    localparam logic [CNT_W-1:0]      c_CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]      c_TIMEOUT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_LAYERS-1:0] c_START_ONE  = NUM_LAYERS'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_RUN     = 3'd2,
        S_RELEASE = 3'd3,
        S_FINISH  = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t                  r_state,        w_state_nxt;
    logic [c_IDX_W-1:0]      r_cur_layer,    w_cur_layer_nxt;
    logic [CNT_W-1:0]        r_timer,        w_timer_nxt;
    logic [CNT_W-1:0]        r_layer_cycles, w_layer_cycles_nxt;
    logic [CNT_W-1:0]        r_total_cycles, w_total_cycles_nxt;
    logic                    r_all_done,     w_all_done_nxt;
    logic                    r_error,        w_error_nxt;
    logic [c_IDX_W-1:0]      r_err_layer,    w_err_layer_nxt;
    logic [NUM_LAYERS-1:0]   r_layer_start,  w_layer_start_nxt;

    logic                    w_done_cur;
    logic                    w_timeout;
    logic [CNT_W-1:0]        w_total_inc;

    // Only the engine currently being driven is listened to.
    assign w_done_cur  = layer_done[r_cur_layer];
    // >= rather than == so that a timer which slipped past the limit while
    // leaving ARM can still trip the timeout in RUN.
    assign w_timeout   = (r_timer >= c_TIMEOUT_M1);
    assign w_total_inc = (r_total_cycles == '1) ? r_total_cycles
                                                : r_total_cycles + c_CNT_ONE;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cur_layer    <= '0;
            r_timer        <= '0;
            r_layer_cycles <= '0;
            r_total_cycles <= '0;
            r_all_done     <= 1'b0;
            r_error        <= 1'b0;
            r_err_layer    <= '0;
            r_layer_start  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cur_layer    <= w_cur_layer_nxt;
            r_timer        <= w_timer_nxt;
            r_layer_cycles <= w_layer_cycles_nxt;
            r_total_cycles <= w_total_cycles_nxt;
            r_all_done     <= w_all_done_nxt;
            r_error        <= w_error_nxt;
            r_err_layer    <= w_err_layer_nxt;
            r_layer_start  <= w_layer_start_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt        = r_state;
        w_cur_layer_nxt    = r_cur_layer;
        w_timer_nxt        = r_timer;
        w_layer_cycles_nxt = r_layer_cycles;
        w_total_cycles_nxt = r_total_cycles;
        w_all_done_nxt     = r_all_done;
        w_error_nxt        = r_error;
        w_err_layer_nxt    = r_err_layer;

        if (abort) begin
            // Counters and the error flag are left intact for post-mortem.
            w_state_nxt    = S_IDLE;
            w_all_done_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_FINISH, S_ERROR: begin
                    if (run) begin
                        w_state_nxt        = S_ARM;
                        w_cur_layer_nxt    = '0;
                        w_all_done_nxt     = 1'b0;
                        w_error_nxt        = 1'b0;
                        w_total_cycles_nxt = '0;
                        w_timer_nxt        = '0;
                    end
                end

                S_ARM: begin
                    // A done still high here is left over from the previous
                    // inference; wait for the engine to clear it on start.
                    w_total_cycles_nxt = w_total_inc;
                    if (!w_done_cur) begin
                        w_state_nxt = S_RUN;
                        w_timer_nxt = r_timer + c_CNT_ONE;
                    end else if (w_timeout) begin
                        w_state_nxt     = S_ERROR;
                        w_error_nxt     = 1'b1;
                        w_err_layer_nxt = r_cur_layer;
                    end else begin
                        w_timer_nxt = r_timer + c_CNT_ONE;
                    end
                end

                S_RUN: begin
                    w_total_cycles_nxt = w_total_inc;
                    // Done is tested before timeout so a same-cycle done wins.
                    if (w_done_cur) begin
                        w_state_nxt        = S_RELEASE;
                        w_layer_cycles_nxt = r_timer + c_CNT_ONE;
                    end else if (w_timeout) begin
                        w_state_nxt     = S_ERROR;
                        w_error_nxt     = 1'b1;
                        w_err_layer_nxt = r_cur_layer;
                    end else begin
                        w_timer_nxt = r_timer + c_CNT_ONE;
                    end
                end

                S_RELEASE: begin
                    w_total_cycles_nxt = w_total_inc;
                    if (r_cur_layer == c_LAST_LAYER) begin
                        w_state_nxt    = S_FINISH;
                        w_all_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = S_ARM;
                        w_cur_layer_nxt = r_cur_layer + c_IDX_ONE;
                        w_timer_nxt     = '0;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        // Starts are decoded from the next state so they come straight off a
        // flop and are guaranteed one-hot or zero.
        w_layer_start_nxt = '0;
        if ((w_state_nxt == S_ARM) || (w_state_nxt == S_RUN)) begin
            w_layer_start_nxt = c_START_ONE << w_cur_layer_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign layer_start  = r_layer_start;
    assign busy         = (r_state == S_ARM) || (r_state == S_RUN) ||
                          (r_state == S_RELEASE);
    assign all_done     = r_all_done;
    assign error        = r_error;
    assign err_layer    = r_err_layer;
    assign cur_layer    = r_cur_layer;
    assign layer_cycles = r_layer_cycles;
    assign total_cycles = r_total_cycles;

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_cnn_layer_sequencer
//  Description : Self-checking bench for cnn_layer_sequencer. Behavioural
//                layer engines respond to the starts; expected layer
//                completions, finish and timeout events are queued when a run
//                is issued and a monitor pops and compares them as the DUT
//                produces them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cnn_layer_sequencer;

    localparam int NL = 6;
    localparam int TO = 16;
    localparam int CW = 32;
    localparam int IW = 3;

    localparam int EV_LAYER = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int     kind;
        int     idx;
        longint val;
    } ev_t;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          run   = 1'b0;
    logic          abort = 1'b0;
    logic [NL-1:0] layer_done;
    logic [NL-1:0] layer_start;
    logic          busy;
    logic          all_done;
    logic          error;
    logic [IW-1:0] err_layer;
    logic [IW-1:0] cur_layer;
    logic [CW-1:0] layer_cycles;
    logic [CW-1:0] total_cycles;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    always #5 clk = ~clk;

    cnn_layer_sequencer #(
        .NUM_LAYERS     (NL),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .abort        (abort),
        .layer_done   (layer_done),
        .layer_start  (layer_start),
        .busy         (busy),
        .all_done     (all_done),
        .error        (error),
        .err_layer    (err_layer),
        .cur_layer    (cur_layer),
        .layer_cycles (layer_cycles),
        .total_cycles (total_cycles)
    );

    // ------------------------------------------------------------------
    // Behavioural engines: done rises lat edges after start first goes high,
    // stays high until the next start, engine waits for start low before
    // accepting a new start. lat == 0 means the engine never finishes.
    // ------------------------------------------------------------------
    int   lat[NL];
    logic eng_clr = 1'b0;
    int   e_cnt[NL];
    logic e_busy[NL];
    logic e_wait[NL];

    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (reset || eng_clr) begin
                e_busy[i]     <= 1'b0;
                e_wait[i]     <= 1'b0;
                e_cnt[i]      <= 0;
                layer_done[i] <= 1'b0;
            end else if (e_busy[i]) begin
                if (lat[i] != 0 && e_cnt[i] == lat[i] - 1) begin
                    layer_done[i] <= 1'b1;
                    e_busy[i]     <= 1'b0;
                    e_wait[i]     <= 1'b1;
                end else begin
                    e_cnt[i] <= e_cnt[i] + 1;
                end
            end else if (e_wait[i]) begin
                if (!layer_start[i]) e_wait[i] <= 1'b0;
            end else if (layer_start[i]) begin
                layer_done[i] <= 1'b0;
                e_busy[i]     <= 1'b1;
                e_cnt[i]      <= 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired, got no event expected one", name);
    endtask

    task automatic sb_check(input int kind, input int idx, input longint val);
        ev_t e;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: got kind %0d idx %0d val %0d expected none",
                     kind, idx, val);
            return;
        end
        e = sb.pop_front();
        if (e.kind == kind && e.idx == idx && e.val == val) n_pass++;
        else $display("FAIL sb_event: got kind %0d idx %0d val %0d expected kind %0d idx %0d val %0d",
                      kind, idx, val, e.kind, e.idx, e.val);
    endtask

    function automatic int onehot_idx(input logic [NL-1:0] v);
        for (int i = 0; i < NL; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Minimum cost of a layer: engine latency + 1 ARM + 1 RELEASE.
    function automatic longint run_total();
        longint t = 0;
        for (int i = 0; i < NL; i++) t += lat[i] + 2;
        return t;
    endfunction

    task automatic push_layers(input int first, input int last);
        for (int i = first; i <= last; i++) sb.push_back('{EV_LAYER, i, longint'(lat[i] + 1)});
    endtask

    task automatic push_full_run();
        push_layers(0, NL - 1);
        sb.push_back('{EV_DONE, 0, run_total()});
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [NL-1:0] p_start = '0;
    logic          p_done  = 1'b0;
    logic          p_err   = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (p_start != '0 && layer_start == '0 && busy)
                    sb_check(EV_LAYER, onehot_idx(p_start), longint'(layer_cycles));
                if (!p_done && all_done) begin
                    sb_check(EV_DONE, 0, longint'(total_cycles));
                    check("finish_busy", busy, 0);
                end
                if (!p_err && error) begin
                    sb_check(EV_ERR, int'(err_layer), longint'(total_cycles));
                    check("err_outputs", {layer_start, all_done, busy}, 0);
                end
                if ($countones(layer_start) > 1)
                    check("start_onehot", $countones(layer_start), 1);
            end
            p_start = layer_start;
            p_done  = all_done;
            p_err   = error;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic do_run();
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
    endtask

    task automatic pulse_eng_clr();
        @(posedge clk); #1 eng_clr = 1'b1;
        @(posedge clk); #1 eng_clr = 1'b0;
    endtask

    task automatic wait_end(input string name, input int limit);
        int n = 0;
        while (!(all_done || error) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!(all_done || error)) fail_now(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start(input string name, input int idx, input int limit);
        int n = 0;
        while (!layer_start[idx] && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!layer_start[idx]) fail_now(name);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        lat = '{3, 4, 5, 6, 7, 8};
        repeat (2) @(posedge clk);
        #3;
        check("reset_ctrl", {layer_start, busy, all_done, error, err_layer, cur_layer}, 0);
        check("reset_cnt", {layer_cycles, total_cycles}, 0);
        @(negedge clk) reset = 1'b0;

        // 1: plain run, layer_cycles = lat+1, total = sum(lat)+12 = 45
        push_full_run();
        do_run();
        check("t1_start0", layer_start, 1);
        check("t1_busy", busy, 1);
        wait_end("t1_wait", 300);
        check("t1_all_done", all_done, 1);

        // 2: every done still high from run 1; ARM must hold until it drops
        push_full_run();
        do_run();
        check("t2_all_done_clr", all_done, 0);
        check("t2_start0", layer_start, 1);
        wait_end("t2_wait", 300);
        check("t2_all_done", all_done, 1);

        // 3: layer 3 hangs -> error 16 cycles after its start, total 18+16
        lat[3] = 0;
        push_layers(0, 2);
        sb.push_back('{EV_ERR, 3, longint'((3 + 2) + (4 + 2) + (5 + 2) + TO)});
        do_run();
        wait_end("t3_wait", 300);
        check("t3_error", error, 1);
        check("t3_err_layer", err_layer, 3);

        // 5: layer 4 done exactly when timer = TO-1 -> no error
        pulse_eng_clr();
        lat = '{3, 4, 5, 6, 15, 8};
        push_full_run();
        do_run();
        check("t5_err_clr", error, 0);
        wait_end("t5_wait", 300);
        check("t5_no_error", error, 0);
        check("t5_all_done", all_done, 1);

        // 4: abort together with run in the middle of layer 2
        lat = '{3, 4, 5, 6, 7, 8};
        push_layers(0, 1);
        do_run();
        wait_start("t4_wait_l2", 2, 100);
        @(posedge clk); @(posedge clk);
        #1 abort = 1'b1; run = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0; run = 1'b0;
        check("t4_idle", {busy, layer_start, all_done}, 0);
        check("t4_cur_hold", cur_layer, 2);
        repeat (3) @(posedge clk);
        #1 check("t4_run_ignored", {busy, layer_start}, 0);
        check("t4_sb_drained", sb.size(), 0);
        push_full_run();
        do_run();
        check("t4_restart0", layer_start, 1);
        wait_end("t4_wait", 300);

        // 6: asynchronous reset mid-RUN, then a clean run
        push_layers(0, 0);
        do_run();
        wait_start("t6_wait_l1", 1, 100);
        @(posedge clk); @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("t6_async_ctrl", {layer_start, busy, all_done, error, err_layer, cur_layer}, 0);
        check("t6_async_cnt", {layer_cycles, total_cycles}, 0);
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        check("t6_sb_drained", sb.size(), 0);
        push_full_run();
        do_run();
        wait_end("t6_wait", 300);
        check("t6_all_done", all_done, 1);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
